// File: rtl/attn_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : attn_dot_seq
//  Description : Dot-product sequencer feeding the FP32 attention-score PE.
//                Buffers (a, b) element pairs in a small FIFO and issues them
//                to the PE one at a time. Each returned partial sum is chained
//                back as the next psum. The final score is presented on a
//                valid/ready result port.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                cmd_*             - length command (valid/ready)
//                s_*               - element-pair input stream (valid/ready)
//                pe_*              - PE issue port and PE result return
//                res_*             - final score output (valid/ready)
//                busy              - sequencer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module attn_dot_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_a,
    input  logic [31:0]      s_b,
    output logic             pe_in_valid,
    output logic [31:0]      pe_a,
    output logic [31:0]      pe_b,
    output logic [31:0]      pe_psum,
    input  logic             pe_out_valid,
    input  logic [31:0]      pe_psum_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_bits,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t           state_q;
    logic [31:0]      acc_q;
    logic [LEN_W-1:0] rem_q;
    logic             pe_in_valid_q;
    logic [31:0]      pe_a_q;
    logic [31:0]      pe_b_q;
    logic [31:0]      pe_psum_q;
    logic             res_valid_q;
    logic [31:0]      res_bits_q;

    // ------------------------------------------------------------------
    // Element-pair FIFO. Pointers carry one extra wrap bit so that full
    // and empty are distinguishable without a separate counter.
    // ------------------------------------------------------------------
    logic [63:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [63:0]   fifo_head;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == PW'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = s_valid && !fifo_full;
    // Pop only when the FSM actually issues the head to the PE.
    assign pop        = (state_q == S_ISSUE) && !fifo_empty;
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q[AW-1:0]] <= {s_a, s_b};
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs. Only one PE transaction is
    // ever outstanding: ISSUE always moves to WAIT, and WAIT only leaves
    // on the PE result strobe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acc_q         <= 32'h0000_0000;
            rem_q         <= '0;
            pe_in_valid_q <= 1'b0;
            pe_a_q        <= 32'h0000_0000;
            pe_b_q        <= 32'h0000_0000;
            pe_psum_q     <= 32'h0000_0000;
            res_valid_q   <= 1'b0;
            res_bits_q    <= 32'h0000_0000;
        end else begin
            pe_in_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rem_q <= cmd_len;
                        acc_q <= 32'h0000_0000;
                        if (cmd_len == '0) begin
                            // Empty dot product: score is +0.0.
                            state_q     <= S_OUT;
                            res_valid_q <= 1'b1;
                            res_bits_q  <= 32'h0000_0000;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!fifo_empty) begin
                        pe_in_valid_q <= 1'b1;
                        pe_a_q        <= fifo_head[63:32];
                        pe_b_q        <= fifo_head[31:0];
                        pe_psum_q     <= acc_q;
                        rem_q         <= rem_q - LEN_W'(1);
                        state_q       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pe_out_valid) begin
                        acc_q <= pe_psum_out;
                        if (rem_q == '0) begin
                            state_q     <= S_OUT;
                            res_valid_q <= 1'b1;
                            res_bits_q  <= pe_psum_out;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // cmd_ready is gated by rst so it reads low during the reset cycle itself.
    assign cmd_ready   = (state_q == S_IDLE) && !rst;
    assign s_ready     = !fifo_full;
    assign busy        = (state_q != S_IDLE);
    assign pe_in_valid = pe_in_valid_q;
    assign pe_a        = pe_a_q;
    assign pe_b        = pe_b_q;
    assign pe_psum     = pe_psum_q;
    assign res_valid   = res_valid_q;
    assign res_bits    = res_bits_q;

endmodule
`default_nettype wire

// File: tb/tb_attn_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_attn_dot_seq
//  Description : Directed self-checking bench for attn_dot_seq. A simple PE
//                responder returns hand-computed FP32 results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_attn_dot_seq;

    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 16;
    localparam int PE_LAT     = 3;

    localparam logic [31:0] F0  = 32'h0000_0000;
    localparam logic [31:0] F1  = 32'h3F80_0000;
    localparam logic [31:0] F2  = 32'h4000_0000;
    localparam logic [31:0] F3  = 32'h4040_0000;
    localparam logic [31:0] F4  = 32'h4080_0000;
    localparam logic [31:0] F5  = 32'h40A0_0000;
    localparam logic [31:0] F6  = 32'h40C0_0000;
    localparam logic [31:0] F9  = 32'h4110_0000;
    localparam logic [31:0] F10 = 32'h4120_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [31:0]      s_a = '0;
    logic [31:0]      s_b = '0;
    logic             pe_in_valid;
    logic [31:0]      pe_a;
    logic [31:0]      pe_b;
    logic [31:0]      pe_psum;
    logic             pe_out_valid = 1'b0;
    logic [31:0]      pe_psum_out = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_bits;
    logic             busy;

    int n_chk = 0;
    int n_err = 0;
    int n_pulse = 0;

    attn_dot_seq #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (LEN_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .pe_in_valid  (pe_in_valid),
        .pe_a         (pe_a),
        .pe_b         (pe_b),
        .pe_psum      (pe_psum),
        .pe_out_valid (pe_out_valid),
        .pe_psum_out  (pe_psum_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_bits     (res_bits),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pe_in_valid === 1'b1) n_pulse++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        for (int i = 0; i < 200 && !done; i++) begin
            if (s_ready) done = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        if (!done) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_cmd(input logic [LEN_W-1:0] len);
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = len;
        for (int i = 0; i < 200 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) chk("cmd_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_issue();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (pe_in_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    // Wait for one issue, check its operands, then return a result after PE_LAT.
    task automatic pe_serve(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] epsum, input logic [31:0] result);
        wait_issue();
        chk({tag, "_a"}, pe_a, ea);
        chk({tag, "_b"}, pe_b, eb);
        chk({tag, "_psum"}, pe_psum, epsum);
        tick();
        chk({tag, "_pulse_1cyc"}, {31'd0, pe_in_valid}, 32'd0);
        for (int i = 1; i < PE_LAT; i++) tick();
        pe_out_valid = 1'b1;
        pe_psum_out  = result;
        tick();
        pe_out_valid = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [31:0] exp);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_res_bits"}, res_bits, exp);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_res_drop"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int p0;

        // ---------------- reset ----------------
        rst = 1'b1;
        tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_bits", res_bits, F0);
        chk("rst_pe_in_valid", {31'd0, pe_in_valid}, 32'd0);
        chk("rst_pe_a", pe_a, F0);
        chk("rst_pe_psum", pe_psum, F0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // ---------------- single element 2.0 * 3.0 ----------------
        push_pair(F2, F3);
        p0 = n_pulse;
        send_cmd(16'd1);
        pe_serve("t1", F2, F3, F0, F6);
        take_result("t1", F6);
        chk("t1_pulses", 32'(n_pulse - p0), 32'd1);

        // ---------------- four elements A=[1,2,3,4] B=1 ----------------
        push_pair(F1, F1);
        push_pair(F2, F1);
        push_pair(F3, F1);
        push_pair(F4, F1);
        p0 = n_pulse;
        send_cmd(16'd4);
        pe_serve("t2e0", F1, F1, F0, F1);
        pe_serve("t2e1", F2, F1, F1, F3);
        pe_serve("t2e2", F3, F1, F3, F6);
        pe_serve("t2e3", F4, F1, F6, F10);
        take_result("t2", F10);
        chk("t2_pulses", 32'(n_pulse - p0), 32'd4);

        // ---------------- zero length ----------------
        p0 = n_pulse;
        send_cmd(16'd0);
        take_result("t3", F0);
        tick();
        chk("t3_pulses", 32'(n_pulse - p0), 32'd0);

        // ---------------- pairs ahead of command, FIFO fills ----------------
        push_pair(F1, F1);
        push_pair(F2, F1);
        push_pair(F3, F1);
        push_pair(F4, F1);
        chk("t4_full_s_ready", {31'd0, s_ready}, 32'd0);
        tick();
        chk("t4_still_full", {31'd0, s_ready}, 32'd0);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        fork
            push_pair(F5, F1);
            begin
                send_cmd(16'd3);
                pe_serve("t4e0", F1, F1, F0, F1);
                pe_serve("t4e1", F2, F1, F1, F3);
                pe_serve("t4e2", F3, F1, F3, F6);
            end
        join
        take_result("t4a", F6);
        send_cmd(16'd2);
        pe_serve("t4f0", F4, F1, F0, F4);
        pe_serve("t4f1", F5, F1, F4, F9);
        take_result("t4b", F9);

        // ---------------- result backpressure ----------------
        push_pair(F1, F1);
        send_cmd(16'd1);
        pe_serve("t5", F1, F1, F0, F1);
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_valid", {31'd0, res_valid}, 32'd1);
            chk("t5_hold_bits", res_bits, F1);
            chk("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            if (i < 2) begin
                chk("t5_s_ready", {31'd0, s_ready}, 32'd1);
                s_valid = 1'b1;
                s_a     = F5;
                s_b     = F5;
            end else begin
                s_valid = 1'b0;
            end
            tick();
        end
        s_valid = 1'b0;
        take_result("t5", F1);

        // ---------------- reset in WAIT ----------------
        push_pair(F3, F3);
        push_pair(F4, F4);
        send_cmd(16'd4);
        wait_issue();
        chk("t6_first_a", pe_a, F5);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_s_ready", {31'd0, s_ready}, 32'd1);
        chk("t6_res_valid", {31'd0, res_valid}, 32'd0);
        push_pair(F2, F3);
        p0 = n_pulse;
        send_cmd(16'd1);
        pe_serve("t6", F2, F3, F0, F6);
        take_result("t6", F6);
        chk("t6_pulses", 32'(n_pulse - p0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
